// File: rtl/link_arbiter_if.sv
// Link payload type and the req/ack link interface shared by all ports.
//   sender   : drives req and packet, observes ack
//   receiver : observes req and packet, drives ack
package link_pkg;

  localparam int unsigned DATA_W = 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
  } packet_t;

endpackage

interface link_if;
  import link_pkg::*;

  logic    req;
  logic    ack;
  packet_t packet;

  modport sender   (output req, output packet, input ack);
  modport receiver (input req, input packet, output ack);
endinterface

// File: rtl/link_arbiter.sv
// Round-robin arbiter merging NUM_INPUTS upstream links into one downstream
// link through a single-entry output slot. It sustains one packet per cycle.
//   clock       : sole clock, rising edge
//   reset       : asynchronous, active-low
//   enable      : low freezes all state and suppresses every handshake
//   input_mask  : bit i high makes input i eligible
//   input_links : upstream links (ack is combinational)
//   output_link : downstream link driven from the slot
//   last_source : index of the input whose packet occupies the slot
//   quiescent   : high while the slot is empty
module link_arbiter #(
  parameter int unsigned NUM_INPUTS = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_INPUTS-1:0]         input_mask,
  link_if.receiver                      input_links [NUM_INPUTS],
  link_if.sender                        output_link,
  output logic [$clog2(NUM_INPUTS)-1:0] last_source,
  output logic                          quiescent
);
  import link_pkg::*;

  localparam int unsigned PW = $clog2(NUM_INPUTS);

  logic                  slot_valid;
  packet_t               slot_pkt;
  logic [PW-1:0]         ptr;

  logic [NUM_INPUTS-1:0] req_vec;
  packet_t               pkt_arr [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] cand;
  logic [NUM_INPUTS-1:0] grant_vec;
  logic                  grant_valid;
  logic [PW-1:0]         grant_idx;
  int unsigned           scan;
  logic                  drain;
  logic                  can_accept;
  logic                  do_grant;

  // Flatten the interface array into plain vectors.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
    assign req_vec[i]          = input_links[i].req;
    assign pkt_arr[i]          = input_links[i].packet;
    assign input_links[i].ack  = grant_vec[i];
  end

  assign cand       = req_vec & input_mask;
  assign drain      = enable & slot_valid & output_link.ack;
  // Reset is folded in so no ack can leak while reset is held.
  assign can_accept = enable & reset & (~slot_valid | drain);
  assign do_grant   = can_accept & grant_valid;
  assign grant_vec  = do_grant ? (NUM_INPUTS'(1) << grant_idx) : '0;

  // First candidate scanning upward from ptr, wrapping without a power-of-two modulo.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan        = 0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      scan = 32'(ptr) + k;
      if (scan >= NUM_INPUTS) scan = scan - NUM_INPUTS;
      if (!grant_valid && cand[PW'(scan)]) begin
        grant_valid = 1'b1;
        grant_idx   = PW'(scan);
      end
    end
  end

  // Slot, pointer and source tracking; a grant overrides a simultaneous drain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_valid  <= 1'b0;
      slot_pkt    <= '0;
      last_source <= '0;
      ptr         <= '0;
    end else if (do_grant) begin
      slot_valid  <= 1'b1;
      slot_pkt    <= pkt_arr[grant_idx];
      last_source <= grant_idx;
      ptr         <= (grant_idx == PW'(NUM_INPUTS - 1)) ? '0 : grant_idx + PW'(1);
    end else if (drain) begin
      slot_valid  <= 1'b0;
    end
  end

  assign output_link.req    = slot_valid & enable;
  assign output_link.packet = slot_pkt;
  assign quiescent          = ~slot_valid;

endmodule

// File: tb/tb_link_arbiter.sv
// Directed bench for link_arbiter: a 4-input instance for the main scenarios
// and a 3-input instance for non-power-of-two pointer wrap.
module tb_link_arbiter;
  import link_pkg::*;

  logic clock;
  logic reset;

  logic       enable4;
  logic [3:0] mask4, req4, ack4;
  packet_t    pkt4 [4];
  logic       oack4;
  logic [1:0] last4;
  logic       q4;

  logic       en3;
  logic [2:0] mask3, req3, ack3;
  packet_t    pkt3 [3];
  logic       oack3;
  logic [1:0] last3;
  logic       q3;

  int n_cmp;
  int n_err;

  link_if in4 [4] ();
  link_if out4 ();
  link_if in3 [3] ();
  link_if out3 ();

  for (genvar i = 0; i < 4; i++) begin : g_l4
    assign in4[i].req    = req4[i];
    assign in4[i].packet = pkt4[i];
    assign ack4[i]       = in4[i].ack;
  end
  for (genvar i = 0; i < 3; i++) begin : g_l3
    assign in3[i].req    = req3[i];
    assign in3[i].packet = pkt3[i];
    assign ack3[i]       = in3[i].ack;
  end
  assign out4.ack = oack4;
  assign out3.ack = oack3;

  link_arbiter #(.NUM_INPUTS(4)) u_dut4 (
    .clock(clock), .reset(reset), .enable(enable4), .input_mask(mask4),
    .input_links(in4), .output_link(out4), .last_source(last4), .quiescent(q4)
  );

  link_arbiter #(.NUM_INPUTS(3)) u_dut3 (
    .clock(clock), .reset(reset), .enable(en3), .input_mask(mask3),
    .input_links(in3), .output_link(out3), .last_source(last3), .quiescent(q3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset   = 1'b0;
    enable4 = 1'b1;
    mask4   = 4'hF;
    req4    = 4'hF;
    oack4   = 1'b1;
    for (int i = 0; i < 4; i++) pkt4[i] = packet_t'(8'hA0 + i);
    en3   = 1'b1;
    mask3 = 3'b111;
    req3  = 3'b000;
    oack3 = 1'b1;
    for (int i = 0; i < 3; i++) pkt3[i] = packet_t'(8'hB0 + i);

    // Reset state, with every input requesting.
    repeat (2) @(posedge clock);
    #1;
    check("rst_quiescent", 32'(q4), 32'd1);
    check("rst_out_req", 32'(out4.req), 32'd0);
    check("rst_last", 32'(last4), 32'd0);
    check("rst_acks", 32'(ack4), 32'd0);

    // Full-rate round robin, all inputs requesting, ack always high.
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rr_first_ack", 32'(ack4), 32'h1);
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_req", 32'(out4.req), 32'd1);
      check("rr_pkt", 32'(out4.packet), 32'hA0 + 32'(k % 4));
      check("rr_last", 32'(last4), 32'(k % 4));
      check("rr_ack", 32'(ack4), 32'(1 << ((k + 1) % 4)));
    end
    req4 = 4'h0;
    step();
    check("rr_drain_q", 32'(q4), 32'd1);
    check("rr_drain_req", 32'(out4.req), 32'd0);

    // Move pointer to 2 by granting input 1, then let it drain.
    req4 = 4'b0010;
    #1;
    check("bp_setup_ack", 32'(ack4), 32'b0010);
    step();
    req4 = 4'b0000;
    step();
    // Inputs 1 and 3 with backpressure: 3 wins from p=2.
    req4  = 4'b1010;
    oack4 = 1'b0;
    #1;
    check("bp_ack3", 32'(ack4), 32'b1000);
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold_pkt", 32'(out4.packet), 32'hA3);
      check("bp_hold_last", 32'(last4), 32'd3);
      check("bp_hold_req", 32'(out4.req), 32'd1);
      check("bp_hold_noack", 32'(ack4), 32'd0);
    end
    oack4 = 1'b1;
    #1;
    check("bp_ack1_on_drain", 32'(ack4), 32'b0010);
    step();
    check("bp_pkt1", 32'(out4.packet), 32'hA1);
    check("bp_last1", 32'(last4), 32'd1);
    check("bp_req1", 32'(out4.req), 32'd1);
    req4 = 4'b0000;
    step();
    check("bp_empty", 32'(q4), 32'd1);

    // Masked requester is ignored; unmasking takes effect immediately (p=2).
    mask4 = 4'b1011;
    req4  = 4'b0100;
    #1;
    check("mask_noack", 32'(ack4), 32'd0);
    repeat (2) begin
      step();
      check("mask_out_req", 32'(out4.req), 32'd0);
      check("mask_quiescent", 32'(q4), 32'd1);
    end
    mask4 = 4'hF;
    #1;
    check("unmask_ack", 32'(ack4), 32'b0100);
    step();
    check("unmask_pkt", 32'(out4.packet), 32'hA2);
    mask4 = 4'b1011;
    oack4 = 1'b0;
    req4  = 4'b0000;
    step();
    check("mask_slot_kept", 32'(out4.packet), 32'hA2);
    check("mask_slot_req", 32'(out4.req), 32'd1);
    oack4 = 1'b1;
    mask4 = 4'hF;
    step();
    check("mask_drained", 32'(q4), 32'd1);

    // Enable low freezes a 0x55 packet despite downstream ack (p=3 -> grant 0).
    pkt4[0] = packet_t'(8'h55);
    req4    = 4'b0001;
    oack4   = 1'b0;
    #1;
    check("en_setup_ack", 32'(ack4), 32'b0001);
    step();
    req4    = 4'b0010;
    oack4   = 1'b1;
    enable4 = 1'b0;
    #1;
    check("en_low_req", 32'(out4.req), 32'd0);
    check("en_low_ack", 32'(ack4), 32'd0);
    repeat (2) begin
      step();
      check("en_low_hold_q", 32'(q4), 32'd0);
      check("en_low_hold_req", 32'(out4.req), 32'd0);
      check("en_low_hold_pkt", 32'(out4.packet), 32'h55);
      check("en_low_hold_last", 32'(last4), 32'd0);
    end
    req4    = 4'b0000;
    enable4 = 1'b1;
    #1;
    check("en_back_req", 32'(out4.req), 32'd1);
    check("en_back_pkt", 32'(out4.packet), 32'h55);
    step();
    check("en_drain_q", 32'(q4), 32'd1);
    step();
    check("en_drain_once", 32'(out4.req), 32'd0);
    pkt4[0] = packet_t'(8'hA0);

    // Asynchronous reset mid-cycle with a full slot (p=1 -> grant 2).
    req4  = 4'b0100;
    oack4 = 1'b0;
    #1;
    check("ar_setup_ack", 32'(ack4), 32'b0100);
    step();
    check("ar_full_req", 32'(out4.req), 32'd1);
    req4 = 4'b1010;
    #2;
    reset = 1'b0;
    #1;
    check("ar_req_fall", 32'(out4.req), 32'd0);
    check("ar_quiescent", 32'(q4), 32'd1);
    check("ar_last", 32'(last4), 32'd0);
    check("ar_acks", 32'(ack4), 32'd0);
    step();
    check("ar_held_q", 32'(q4), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("ar_rel_q", 32'(q4), 32'd1);
    check("ar_rel_req", 32'(out4.req), 32'd0);
    check("ar_first_ack", 32'(ack4), 32'b0010);
    step();
    check("ar_first_pkt", 32'(out4.packet), 32'hA1);
    check("ar_first_last", 32'(last4), 32'd1);
    req4  = 4'b0000;
    oack4 = 1'b1;
    step();
    check("ar_end_q", 32'(q4), 32'd1);

    // Three-input wrap: grant 1 (p=2), grant 2 twice (p wraps to 0), then {0,2} -> 0.
    req3 = 3'b010;
    #1;
    check("n3_ack1", 32'(ack3), 32'b010);
    step();
    check("n3_last1", 32'(last3), 32'd1);
    check("n3_pkt1", 32'(out3.packet), 32'hB1);
    req3 = 3'b100;
    #1;
    check("n3_ack2a", 32'(ack3), 32'b100);
    step();
    check("n3_last2a", 32'(last3), 32'd2);
    check("n3_pkt2a", 32'(out3.packet), 32'hB2);
    check("n3_ack2b", 32'(ack3), 32'b100);
    step();
    check("n3_last2b", 32'(last3), 32'd2);
    check("n3_req2b", 32'(out3.req), 32'd1);
    req3 = 3'b101;
    #1;
    check("n3_wrap_ack0", 32'(ack3), 32'b001);
    step();
    check("n3_last0", 32'(last3), 32'd0);
    check("n3_pkt0", 32'(out3.packet), 32'hB0);
    req3 = 3'b000;
    step();
    check("n3_end_q", 32'(q3), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
